// File: rtl/melody_player.sv
// melody_player: accepts timed notes over valid/ready and drives an active-low buzzer with the tone.
// Defining MELODY_GAP_EN inserts GAP_TICKS silent ticks after every completed note.
module melody_player #(
    parameter int TICK_CYCLES = 12_500_000,
    parameter int GAP_TICKS   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        note_valid,
    output logic        note_ready,
    input  logic [19:0] note_half,
    input  logic [7:0]  note_len,
    input  logic        stop,
    output logic        busy,
    output logic        done,
    output logic        beep_n
);

    localparam int TW = $clog2(TICK_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    if (TICK_CYCLES < 2) begin : g_bad_tick
        $error("melody_player: TICK_CYCLES must be at least 2");
    end
    if (GAP_TICKS < 1) begin : g_bad_gap
        $error("melody_player: GAP_TICKS must be at least 1");
    end

`ifdef MELODY_GAP_EN
    localparam logic [7:0] GAP_LEN = 8'(GAP_TICKS);
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1} state_t;
`endif

    state_t          state_r, state_s;
    logic [TW-1:0]   tick_r, tick_s;
    logic [7:0]      rem_r, rem_s;
    logic [19:0]     half_r, half_s;
    logic [19:0]     hcnt_r, hcnt_s;
    logic            phase_r, phase_s;
    logic            done_r, done_s;
    logic            tick_last_s;
    logic            seg_last_s;

    // A segment (note or gap) ends on the last cycle of its last tick.
    assign tick_last_s = (tick_r == TICK_LAST);
    assign seg_last_s  = tick_last_s && (rem_r == 8'd1);

    assign note_ready = (state_r == IDLE) && !stop;
    assign busy       = (state_r != IDLE);
    assign done       = done_r;
    assign beep_n     = !((state_r == PLAY) && phase_r);

    // Next-state, counters and completion pulse; stop overrides every state.
    always_comb begin
        state_s = state_r;
        tick_s  = tick_r;
        rem_s   = rem_r;
        half_s  = half_r;
        hcnt_s  = hcnt_r;
        phase_s = phase_r;
        done_s  = 1'b0;
        if (stop) begin
            state_s = IDLE;
            phase_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (note_valid) begin
                        half_s  = note_half;
                        rem_s   = note_len;
                        tick_s  = '0;
                        hcnt_s  = 20'd0;
                        phase_s = 1'b0;
                        if (note_len != 8'd0) begin
                            state_s = PLAY;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                PLAY: begin
                    if (tick_last_s) begin
                        tick_s = '0;
                        rem_s  = rem_r - 8'd1;
                    end else begin
                        tick_s = tick_r + TW'(1);
                        rem_s  = rem_r;
                    end
                    // A zero half-period is a rest: the tone counter stays parked.
                    if (half_r != 20'd0) begin
                        if (hcnt_r == (half_r - 20'd1)) begin
                            hcnt_s  = 20'd0;
                            phase_s = ~phase_r;
                        end else begin
                            hcnt_s = hcnt_r + 20'd1;
                        end
                    end else begin
                        hcnt_s = hcnt_r;
                    end
                    if (seg_last_s) begin
                        phase_s = 1'b0;
`ifdef MELODY_GAP_EN
                        state_s = GAP;
                        tick_s  = '0;
                        rem_s   = GAP_LEN;
`else
                        state_s = IDLE;
                        done_s  = 1'b1;
`endif
                    end else begin
                        state_s = PLAY;
                    end
                end
`ifdef MELODY_GAP_EN
                GAP: begin
                    if (tick_last_s) begin
                        tick_s = '0;
                        rem_s  = rem_r - 8'd1;
                    end else begin
                        tick_s = tick_r + TW'(1);
                        rem_s  = rem_r;
                    end
                    if (seg_last_s) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = GAP;
                    end
                end
`endif
                default: begin
                    state_s = IDLE;
                    phase_s = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            tick_r  <= '0;
            rem_r   <= 8'd0;
            half_r  <= 20'd0;
            hcnt_r  <= 20'd0;
            phase_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            tick_r  <= tick_s;
            rem_r   <= rem_s;
            half_r  <= half_s;
            hcnt_r  <= hcnt_s;
            phase_r <= phase_s;
            done_r  <= done_s;
        end
    end

endmodule
